// File: rtl/alu_op_sequencer.sv
// -----------------------------------------------------------------------------
// alu_op_sequencer
//
// Initiator side of a 16-bit ALU. Takes one micro-op request at a time over a
// valid/ready handshake, drives the ALU operand/function/write-flag lines for
// one cycle (two for the chained 32-bit add), waits for the ALU's registered
// flags to settle, and returns a single response holding the result, the
// flags and a skipped indication.
//
// Parameters
//   FLAG_WAIT  cycles spent waiting before the ALU flags are sampled (>= 1)
//   CMP_ZERO   1: CMP16 returns RspData = 0; 0: CMP16 returns A - B
//
// Ports
//   Clock       rising-edge clock shared with the ALU
//   Reset       asynchronous, active-low
//   ReqValid    request valid
//   ReqReady    request accepted on ReqValid & ReqReady (high only when idle)
//   ReqOp       MOV16/ADD16/SUB16/AND16/OR16/XOR16/CMP16/ADD32 (0..7)
//   ReqCond     always/Z/!Z/C/!C/N/O/never (0..7)
//   ReqA, ReqB  32-bit operands; 16-bit ops use the low half
//   AluA, AluB  operands to the ALU
//   AluFunSel   ALU function select
//   AluWF       ALU write enable (result and flags register)
//   AluOut      combinational ALU result
//   FlagsIn     registered ALU flags {Z, C, N, O}
//   RspValid    response valid
//   RspReady    response consumed on RspValid & RspReady
//   RspData     result, 16-bit ops zero-extended
//   RspFlags    ALU flags after the op, same layout as FlagsIn
//   RspSkipped  condition was false and the ALU was never written
// -----------------------------------------------------------------------------
module alu_op_sequencer #(
  parameter int FLAG_WAIT = 1,
  parameter bit CMP_ZERO  = 1'b1
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        ReqValid,
  output logic        ReqReady,
  input  logic [2:0]  ReqOp,
  input  logic [2:0]  ReqCond,
  input  logic [31:0] ReqA,
  input  logic [31:0] ReqB,
  output logic [15:0] AluA,
  output logic [15:0] AluB,
  output logic [4:0]  AluFunSel,
  output logic        AluWF,
  input  logic [15:0] AluOut,
  input  logic [3:0]  FlagsIn,
  output logic        RspValid,
  input  logic        RspReady,
  output logic [31:0] RspData,
  output logic [3:0]  RspFlags,
  output logic        RspSkipped
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ISSUE_LO = 3'd1,
    S_ISSUE_HI = 3'd2,
    S_FLAGWAIT = 3'd3,
    S_RESP     = 3'd4
  } state_t;

  localparam logic [2:0] OP_MOV   = 3'b000;
  localparam logic [2:0] OP_ADD   = 3'b001;
  localparam logic [2:0] OP_SUB   = 3'b010;
  localparam logic [2:0] OP_AND   = 3'b011;
  localparam logic [2:0] OP_OR    = 3'b100;
  localparam logic [2:0] OP_XOR   = 3'b101;
  localparam logic [2:0] OP_CMP   = 3'b110;
  localparam logic [2:0] OP_ADD32 = 3'b111;

  localparam logic [4:0] FS_ADC = 5'b10101;

  localparam int              CNT_W     = (FLAG_WAIT > 1) ? $clog2(FLAG_WAIT) : 1;
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(FLAG_WAIT - 1);

  // Flags layout: [3] Z, [2] C, [1] N, [0] O
  function automatic logic cond_true(input logic [2:0] cond, input logic [3:0] flags);
    case (cond)
      3'b000:  cond_true = 1'b1;
      3'b001:  cond_true = flags[3];
      3'b010:  cond_true = ~flags[3];
      3'b011:  cond_true = flags[2];
      3'b100:  cond_true = ~flags[2];
      3'b101:  cond_true = flags[1];
      3'b110:  cond_true = flags[0];
      default: cond_true = 1'b0;
    endcase
  endfunction

  // Function select for the first (or only) ALU cycle of an op.
  function automatic logic [4:0] fun_sel(input logic [2:0] op);
    case (op)
      OP_MOV:   fun_sel = 5'b10000;
      OP_ADD:   fun_sel = 5'b10100;
      OP_SUB:   fun_sel = 5'b10110;
      OP_AND:   fun_sel = 5'b10111;
      OP_OR:    fun_sel = 5'b11000;
      OP_XOR:   fun_sel = 5'b11001;
      OP_CMP:   fun_sel = 5'b10110;
      default:  fun_sel = 5'b10100;  // ADD32 low half is a plain ADD
    endcase
  endfunction

  state_t           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [31:0]      a_q, a_d;
  logic [31:0]      b_q, b_d;
  logic [31:0]      data_q, data_d;
  logic [3:0]       flags_q, flags_d;
  logic             skipped_q, skipped_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    data_d     = data_q;
    flags_d    = flags_q;
    skipped_d  = skipped_q;
    wait_cnt_d = wait_cnt_q;

    ReqReady   = 1'b0;
    RspValid   = 1'b0;
    AluA       = 16'h0000;
    AluB       = 16'h0000;
    AluFunSel  = 5'b00000;
    AluWF      = 1'b0;

    case (state_q)
      S_IDLE: begin
        ReqReady = 1'b1;
        if (ReqValid) begin
          op_d       = ReqOp;
          a_d        = ReqA;
          b_d        = ReqB;
          data_d     = 32'h0000_0000;
          wait_cnt_d = '0;
          // The condition is judged on the flags as they stand at accept.
          if (cond_true(ReqCond, FlagsIn)) begin
            skipped_d = 1'b0;
            state_d   = S_ISSUE_LO;
          end else begin
            skipped_d = 1'b1;
            flags_d   = FlagsIn;
            state_d   = S_RESP;
          end
        end
      end

      S_ISSUE_LO: begin
        AluWF     = 1'b1;
        AluA      = a_q[15:0];
        AluB      = b_q[15:0];
        AluFunSel = fun_sel(op_q);
        data_d[15:0] = (op_q == OP_CMP && CMP_ZERO) ? 16'h0000 : AluOut;
        state_d   = (op_q == OP_ADD32) ? S_ISSUE_HI : S_FLAGWAIT;
      end

      S_ISSUE_HI: begin
        // ADC consumes the carry the ALU registered at the end of ISSUE_LO.
        AluWF         = 1'b1;
        AluA          = a_q[31:16];
        AluB          = b_q[31:16];
        AluFunSel     = FS_ADC;
        data_d[31:16] = AluOut;
        state_d       = S_FLAGWAIT;
      end

      S_FLAGWAIT: begin
        if (wait_cnt_q == WAIT_LAST) begin
          flags_d = FlagsIn;
          state_d = S_RESP;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end

      S_RESP: begin
        RspValid = 1'b1;
        if (RspReady) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q    <= S_IDLE;
      op_q       <= 3'b000;
      a_q        <= 32'h0000_0000;
      b_q        <= 32'h0000_0000;
      data_q     <= 32'h0000_0000;
      flags_q    <= 4'b0000;
      skipped_q  <= 1'b0;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      data_q     <= data_d;
      flags_q    <= flags_d;
      skipped_q  <= skipped_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign RspData    = data_q;
  assign RspFlags   = flags_q;
  assign RspSkipped = skipped_q;

endmodule
